// File: rtl/fc_layer_seq_if.sv
// Stream bundle for the fully-connected neuron sequencer: the activation
// input stream and the result output stream. The producer/consumer side
// uses the master modport; the sequencer uses the slave modport.
interface fc_layer_seq_if #(
  parameter int WIDTH = 8,
  parameter int ZW    = 23
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ZW-1:0]    out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fc_layer_seq.sv
// Sequencer for one combinational fully-connected neuron.
// Collects an IN-element activation frame one beat at a time, holds it on
// layer_x while the neuron's adder tree settles (a multicycle path of SETTLE
// cycles), then captures layer_z into a result register that drains over a
// valid/ready stream. Loading the next frame overlaps draining the previous
// result; a finished frame waits in SETTLE until the result slot is free.
module fc_layer_seq #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int SETTLE = 4,
  localparam int ZW    = WIDTH*2 + $clog2(IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  fc_layer_seq_if.slave           bus,
  output logic signed [WIDTH-1:0] layer_x [0:IN-1],
  input  logic [ZW-1:0]           layer_z,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int CW = $clog2(IN);
  localparam logic [CW-1:0] LAST_IDX    = CW'(IN - 1);
  localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE - 1);

  typedef enum logic {
    ST_LOAD,
    ST_SETTLE
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [3:0]    settle_cnt;
  logic          out_valid_q;
  logic [ZW-1:0] out_data_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.in_ready  = (state == ST_LOAD) && !flush;
  assign busy          = (state == ST_SETTLE) || (count != '0);

  // Frame loading, settle countdown, result capture and the output slot handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      count       <= '0;
      settle_cnt  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err   <= 1'b0;
      for (int i = 0; i < IN; i++) begin
        layer_x[i] <= '0;
      end
    end else if (flush) begin
      state       <= ST_LOAD;
      count       <= '0;
      settle_cnt  <= '0;
      out_valid_q <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        ST_LOAD: begin
          if (bus.in_valid) begin
            layer_x[count] <= bus.in_data;
            if (bus.in_last || (count == LAST_IDX)) begin
              count      <= '0;
              settle_cnt <= SETTLE_INIT;
              state      <= ST_SETTLE;
              // Error when in_last arrives early or the frame fills without it.
              if (bus.in_last != (count == LAST_IDX)) begin
                frame_err <= 1'b1;
              end
              // A short frame leaves no stale activations in the tail.
              if (bus.in_last) begin
                for (int i = 0; i < IN; i++) begin
                  if (i > int'(count)) begin
                    layer_x[i] <= '0;
                  end
                end
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else if (!out_valid_q || bus.out_ready) begin
            out_data_q  <= layer_z;
            out_valid_q <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq with a stub neuron z = ReLU(sum layer_x).
// A frame/result model tracks accepted beats as plain lists and predicts
// each result and the framing error flag; directed scenarios add literal
// expectations for latency, holding, framing, flush and reset.
module tb_fc_layer_seq;
  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int SETTLE = 4;
  localparam int ZW     = WIDTH*2 + $clog2(IN);

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic signed [WIDTH-1:0] layer_x [0:IN-1];
  logic [ZW-1:0]           layer_z;
  logic                    busy;
  logic                    frame_err;

  int checks   = 0;
  int failures = 0;

  int                      acc_z;
  logic signed [WIDTH-1:0] frame_q [$];
  int                      exp_q [$];
  logic                    exp_err = 1'b0;
  int                      model_sum;

  fc_layer_seq_if #(.WIDTH(WIDTH), .ZW(ZW)) bus();

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .layer_x   (layer_x),
    .layer_z   (layer_z),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Stub neuron: signed sum of the frame followed by ReLU.
  always_comb begin
    acc_z = 0;
    for (int i = 0; i < IN; i++) begin
      acc_z = acc_z + int'(layer_x[i]);
    end
    layer_z = (acc_z < 0) ? '0 : ZW'(acc_z);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkFrame(input string name, input int lo, input int hi, input logic signed [7:0] val);
    int bad;
    bad = 0;
    for (int i = lo; i <= hi; i++) begin
      if (layer_x[i] !== val) bad++;
    end
    checkOutput(name, 32'(bad), 32'd0);
  endtask

  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("beat_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(bus.out_valid), 32'd1);
  endtask

  // Model: compare outputs against predictions, then advance to the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      frame_q.delete();
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      checkOutput("frame_err_model", 32'(frame_err), 32'(exp_err));
      if (bus.out_valid === 1'b1) begin
        checkOutput("valid_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) checkOutput("out_data_model", 32'(bus.out_data), 32'(exp_q[0]));
      end
      if (flush) begin
        frame_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (bus.in_valid && bus.in_ready) begin
          frame_q.push_back(bus.in_data);
          if (bus.in_last || frame_q.size() == IN) begin
            model_sum = 0;
            foreach (frame_q[i]) model_sum = model_sum + int'(frame_q[i]);
            if (model_sum < 0) model_sum = 0;
            exp_q.push_back(model_sum);
            if (!(bus.in_last && frame_q.size() == IN)) exp_err = 1'b1;
            frame_q.delete();
          end
        end
      end
    end
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkFrame("rst_layer_x", 0, IN-1, 8'sd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: full frame of ones, latency SETTLE edges after the last beat
    syncDrive();
    for (int i = 0; i < IN; i++) applyStimulus(8'sd1, i == IN-1);
    for (int k = 0; k < SETTLE; k++) begin
      @(negedge clk);
      checkOutput("t1_latency_low", 32'(bus.out_valid), 32'd0);
      if (k == 0) begin
        checkOutput("t1_settle_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("t1_settle_busy", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    checkOutput("t1_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_data", 32'(bus.out_data), 32'd128);
    checkOutput("t1_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    checkOutput("t1_consumed", 32'(bus.out_valid), 32'd0);

    // 2: result A held, frame B waits in SETTLE, then both drain back to back
    syncDrive();
    bus.out_ready = 1'b0;
    for (int i = 0; i < IN; i++) applyStimulus(8'sd2, i == IN-1);
    waitValid("t2_a_valid");
    checkOutput("t2_a_data", 32'(bus.out_data), 32'd256);
    syncDrive();
    for (int i = 0; i < IN; i++) applyStimulus(-8'sd1, i == IN-1);
    repeat (10) @(negedge clk);
    checkOutput("t2_hold_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t2_hold_data", 32'(bus.out_data), 32'd256);
    checkOutput("t2_hold_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t2_hold_busy", 32'(busy), 32'd1);
    checkFrame("t2_hold_layer_x", 0, IN-1, -8'sd1);
    syncDrive();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_a_still", 32'(bus.out_data), 32'd256);
    @(negedge clk);
    checkOutput("t2_b_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t2_b_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    checkOutput("t2_b_consumed", 32'(bus.out_valid), 32'd0);

    // 3: early in_last on beat 9
    syncDrive();
    for (int i = 0; i < 10; i++) applyStimulus(8'sd5, i == 9);
    waitValid("t3_valid");
    checkOutput("t3_data", 32'(bus.out_data), 32'd50);
    checkOutput("t3_err", 32'(frame_err), 32'd1);
    checkFrame("t3_head", 0, 9, 8'sd5);
    checkFrame("t3_tail_zero", 10, IN-1, 8'sd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_err_sticky", 32'(frame_err), 32'd1);
    syncDrive();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd9;
    bus.in_last  = 1'b0;
    @(negedge clk);
    checkOutput("t3_flush_in_ready", 32'(bus.in_ready), 32'd0);
    syncDrive();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_flush_err", 32'(frame_err), 32'd0);
    checkOutput("t3_flush_busy", 32'(busy), 32'd0);

    // 4: frame fills without in_last, following beats start a new frame
    syncDrive();
    for (int i = 0; i < IN; i++) applyStimulus(8'sd1, 1'b0);
    waitValid("t4_valid");
    checkOutput("t4_data", 32'(bus.out_data), 32'd128);
    checkOutput("t4_err", 32'(frame_err), 32'd1);
    syncDrive();
    applyStimulus(8'sd3, 1'b0);
    applyStimulus(8'sd4, 1'b0);
    @(negedge clk);
    checkOutput("t4_next_x0", 32'(layer_x[0]), 32'(8'sd3));
    checkOutput("t4_next_x1", 32'(layer_x[1]), 32'(8'sd4));
    checkOutput("t4_partial_busy", 32'(busy), 32'd1);
    syncDrive();
    flush = 1'b1;
    syncDrive();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_flush_busy", 32'(busy), 32'd0);
    checkOutput("t4_flush_err", 32'(frame_err), 32'd0);

    // 5: flush lands exactly on the capture edge
    syncDrive();
    for (int i = 0; i < IN; i++) applyStimulus(8'sd3, i == IN-1);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("t5_no_valid", 32'(bus.out_valid), 32'd0);
    end
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t5_out_data_kept", 32'(bus.out_data), 32'd128);
    syncDrive();
    for (int i = 0; i < IN; i++) applyStimulus((i < 64) ? 8'sd4 : -8'sd1, i == IN-1);
    waitValid("t5_next_valid");
    checkOutput("t5_next_data", 32'(bus.out_data), 32'd192);

    // 6: asynchronous reset in the middle of loading
    syncDrive();
    applyStimulus(8'sd10, 1'b0);
    applyStimulus(8'sd10, 1'b1);
    waitValid("t6_short_valid");
    checkOutput("t6_short_data", 32'(bus.out_data), 32'd20);
    syncDrive();
    for (int i = 0; i < 60; i++) applyStimulus(8'sd1, 1'b0);
    checkOutput("t6_pre_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("t6_rst_err", 32'(frame_err), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkFrame("t6_rst_layer_x", 0, IN-1, 8'sd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < IN; i++) applyStimulus(8'(i % 5), i == IN-1);
    waitValid("t6_after_valid");
    checkOutput("t6_after_data", 32'(bus.out_data), 32'd253);
    checkOutput("t6_after_err", 32'(frame_err), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
